// File: rtl/nexys_axil_mtimer.sv
// nexys_axil_mtimer: AXI4-Lite machine timer with mtime/mtimecmp, prescaler and tear-free HI shadow
module nexys_axil_mtimer #(
    parameter int PRESCALE = 1,
    parameter int ADDR_W   = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_wvalid,
    output logic              s_wready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic [1:0]        s_bresp,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [ADDR_W-1:0] s_araddr,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic [63:0]       mtime,
    output logic              mtip
);

    localparam logic [31:0] PCNT_MAX = 32'(PRESCALE - 1);

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return r;
    endfunction

    logic              aw_held_q, w_held_q, bvalid_q, rvalid_q, en_q, mtip_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [31:0]       wdata_q, rdata_q, shadow_q, pcnt_q, pcnt_d;
    logic [3:0]        wstrb_q;
    logic [1:0]        bresp_q, rresp_q;
    logic [63:0]       mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;

    logic              aw_hs, w_hs, ar_hs, do_wr, w_ok, r_ok, tick;
    logic              wr_lo, wr_hi, wr_clo, wr_chi, wr_ctl;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdat, rd_val;
    logic [3:0]        wstb;
    logic [2:0]        wsel, rsel;
    logic              unused_bits;

    assign s_awready = !aw_held_q & !bvalid_q;
    assign s_wready  = !w_held_q & !bvalid_q;
    assign s_arready = !rvalid_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;
    assign mtime     = mtime_q;
    assign mtip      = mtip_q;

    assign aw_hs = s_awvalid & s_awready;
    assign w_hs  = s_wvalid & s_wready;
    assign ar_hs = s_arvalid & s_arready;

    // The write commits in the first cycle both halves are present, buffered or arriving now
    assign waddr = aw_held_q ? awaddr_q : s_awaddr;
    assign wdat  = w_held_q ? wdata_q : s_wdata;
    assign wstb  = w_held_q ? wstrb_q : s_wstrb;
    assign do_wr = (aw_held_q | aw_hs) & (w_held_q | w_hs);
    assign wsel  = waddr[4:2];
    assign w_ok  = (waddr[ADDR_W-1:5] == '0) & (wsel <= 3'd4);

    assign wr_lo  = do_wr & w_ok & (wsel == 3'd0);
    assign wr_hi  = do_wr & w_ok & (wsel == 3'd1);
    assign wr_clo = do_wr & w_ok & (wsel == 3'd2);
    assign wr_chi = do_wr & w_ok & (wsel == 3'd3);
    assign wr_ctl = do_wr & w_ok & (wsel == 3'd4);

    assign rsel   = s_araddr[4:2];
    assign r_ok   = (s_araddr[ADDR_W-1:5] == '0) & (rsel <= 3'd4);
    assign rd_val = !r_ok         ? 32'd0 :
                    rsel == 3'd0  ? mtime_q[31:0] :
                    rsel == 3'd1  ? shadow_q :
                    rsel == 3'd2  ? mtimecmp_q[31:0] :
                    rsel == 3'd3  ? mtimecmp_q[63:32] : {31'd0, en_q};

    assign tick        = en_q & (pcnt_q == PCNT_MAX);
    assign unused_bits = ^{waddr[1:0], s_araddr[1:0]};

    // Timer next state: a software write to either mtime half wins over a tick and restarts the prescaler
    always_comb begin
        pcnt_d     = (wr_lo | wr_hi) ? 32'd0 : !en_q ? pcnt_q : tick ? 32'd0 : pcnt_q + 32'd1;
        mtime_d    = wr_lo ? {mtime_q[63:32], merge(mtime_q[31:0], wdat, wstb)} :
                     wr_hi ? {merge(mtime_q[63:32], wdat, wstb), mtime_q[31:0]} :
                     tick  ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = wr_clo ? {mtimecmp_q[63:32], merge(mtimecmp_q[31:0], wdat, wstb)} :
                     wr_chi ? {merge(mtimecmp_q[63:32], wdat, wstb), mtimecmp_q[31:0]} : mtimecmp_q;
    end

    // Timer registers, compare flag, control and the HI shadow captured by LO reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q     <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            en_q       <= 1'b1;
            shadow_q   <= '0;
            mtip_q     <= 1'b0;
        end else begin
            pcnt_q     <= pcnt_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            mtip_q     <= mtime_q >= mtimecmp_q;
            if (wr_ctl && wstb[0]) en_q <= wdat[0];
            if (ar_hs && r_ok && rsel == 3'd0) shadow_q <= mtime_q[63:32];
        end
    end

    // AXI4-Lite channel state: AW/W buffers, B response and registered R data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            aw_held_q <= !do_wr & (aw_held_q | aw_hs);
            w_held_q  <= !do_wr & (w_held_q | w_hs);
            if (aw_hs) awaddr_q <= s_awaddr;
            if (w_hs) begin
                wdata_q <= s_wdata;
                wstrb_q <= s_wstrb;
            end
            if (do_wr) begin
                bvalid_q <= 1'b1;
                bresp_q  <= w_ok ? 2'b00 : 2'b10;
            end else if (s_bready) begin
                bvalid_q <= 1'b0;
            end
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_val;
                rresp_q  <= r_ok ? 2'b00 : 2'b10;
            end else if (s_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nexys_axil_mtimer.sv
// tb_nexys_axil_mtimer: scoreboard bench for the AXI4-Lite machine timer
module tb_nexys_axil_mtimer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b1, s_arvalid = 1'b0, s_rready = 1'b1;
    logic [11:0] s_awaddr = '0, s_araddr = '0;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid, mtip;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;
    logic [63:0] mtime;

    logic        d3_awready, d3_wready, d3_bvalid, d3_arready, d3_rvalid, d3_mtip;
    logic [1:0]  d3_bresp, d3_rresp;
    logic [31:0] d3_rdata;
    logic [63:0] d3_mtime;

    int checks = 0;
    int errors = 0;

    logic [31:0] rq_data[$];
    logic [1:0]  rq_resp[$];
    logic [1:0]  bq[$];

    always #5 clk = ~clk;

    nexys_axil_mtimer #(.PRESCALE(1), .ADDR_W(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .mtime(mtime), .mtip(mtip)
    );

    nexys_axil_mtimer #(.PRESCALE(3), .ADDR_W(12)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .s_awvalid(1'b0), .s_awready(d3_awready), .s_awaddr(12'd0),
        .s_wvalid(1'b0), .s_wready(d3_wready), .s_wdata(32'd0), .s_wstrb(4'd0),
        .s_bvalid(d3_bvalid), .s_bready(1'b1), .s_bresp(d3_bresp),
        .s_arvalid(1'b0), .s_arready(d3_arready), .s_araddr(12'd0),
        .s_rvalid(d3_rvalid), .s_rready(1'b1), .s_rdata(d3_rdata), .s_rresp(d3_rresp),
        .mtime(d3_mtime), .mtip(d3_mtip)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] resp);
        bit ad = 0;
        bit wd = 0;
        int n = 0;
        logic [1:0] e;
        bq.push_back(resp);
        s_awaddr = a; s_wdata = d; s_wstrb = s; s_bready = 1'b1;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        while (!(ad && wd) && n < 20) begin
            if (s_awready) ad = 1;
            if (s_wready) wd = 1;
            cyc();
            n++;
            if (ad) s_awvalid = 1'b0;
            if (wd) s_wvalid = 1'b0;
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        n = 0;
        while (!s_bvalid && n < 20) begin
            cyc();
            n++;
        end
        e = bq.pop_front();
        checks++;
        if (!s_bvalid) begin
            errors++;
            $display("FAIL write_b_timeout addr=%h: bvalid=%b required 1", a, s_bvalid);
        end else if (s_bresp !== e) begin
            errors++;
            $display("FAIL write_bresp addr=%h: got %b required %b", a, s_bresp, e);
        end
        cyc();
    endtask

    task automatic axi_read(input logic [11:0] a, input logic [31:0] d, input logic [1:0] resp);
        int n = 0;
        logic [31:0] ed;
        logic [1:0]  er;
        rq_data.push_back(d);
        rq_resp.push_back(resp);
        s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
        while (!s_arready && n < 20) begin
            cyc();
            n++;
        end
        cyc();
        s_arvalid = 1'b0;
        n = 0;
        while (!s_rvalid && n < 20) begin
            cyc();
            n++;
        end
        ed = rq_data.pop_front();
        er = rq_resp.pop_front();
        checks++;
        if (!s_rvalid || s_rdata !== ed || s_rresp !== er) begin
            errors++;
            $display("FAIL read addr=%h: rvalid=%b rdata=%h rresp=%b required rdata=%h rresp=%b",
                     a, s_rvalid, s_rdata, s_rresp, ed, er);
        end
        cyc();
    endtask

    task automatic test_reset();
        repeat (3) cyc();
        checks++;
        if (mtime !== 64'd0 || mtip !== 1'b0 || s_bvalid !== 1'b0 || s_rvalid !== 1'b0 ||
            s_rdata !== 32'd0 || {s_awready, s_wready, s_arready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_state: mtime=%h mtip=%b bvalid=%b rvalid=%b rdata=%h readies=%b",
                     mtime, mtip, s_bvalid, s_rvalid, s_rdata, {s_awready, s_wready, s_arready});
        end
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (mtime !== 64'(k) || mtip !== 1'b0 || d3_mtime !== 64'(k / 3)) begin
                errors++;
                $display("FAIL count k=%0d: mtime=%0d mtip=%b presc3=%0d required %0d 0 %0d",
                         k, mtime, mtip, d3_mtime, k, k / 3);
            end
            cyc();
        end
        axi_read(12'h000, 32'd8, 2'b00);
    endtask

    task automatic test_rollover();
        axi_write(12'h010, 32'd0, 4'hF, 2'b00);
        axi_write(12'h000, 32'hFFFF_FFFF, 4'hF, 2'b00);
        axi_write(12'h004, 32'd0, 4'hF, 2'b00);
        checks++;
        if (mtime !== 64'h0000_0000_FFFF_FFFF) begin
            errors++;
            $display("FAIL frozen_set: mtime=%h required 00000000ffffffff", mtime);
        end
        axi_write(12'h010, 32'd1, 4'hF, 2'b00);
        checks++;
        if (mtime !== 64'h1_0000_0000) begin
            errors++;
            $display("FAIL carry: mtime=%h required 0000000100000000", mtime);
        end
        axi_write(12'h010, 32'd0, 4'hF, 2'b00);
        axi_write(12'h000, 32'hFFFF_FFF0, 4'hF, 2'b00);
        axi_write(12'h004, 32'd0, 4'hF, 2'b00);
        axi_write(12'h010, 32'd1, 4'hF, 2'b00);
        axi_read(12'h000, 32'hFFFF_FFF1, 2'b00);
        repeat (20) cyc();
        checks++;
        if (mtime[63:32] !== 32'd1) begin
            errors++;
            $display("FAIL hi_moved: mtime_hi=%h required 1", mtime[63:32]);
        end
        axi_read(12'h004, 32'd0, 2'b00);
    endtask

    task automatic test_mtip();
        axi_write(12'h010, 32'd0, 4'hF, 2'b00);
        axi_write(12'h000, 32'd10, 4'hF, 2'b00);
        axi_write(12'h004, 32'd0, 4'hF, 2'b00);
        axi_write(12'h00C, 32'd0, 4'hF, 2'b00);
        axi_write(12'h008, 32'd20, 4'hF, 2'b00);
        axi_write(12'h010, 32'd1, 4'hF, 2'b00);
        for (int k = 0; k < 15; k++) begin
            checks++;
            if (mtime !== 64'(11 + k) || mtip !== (11 + k >= 21)) begin
                errors++;
                $display("FAIL mtip_rise t=%0d: mtime=%0d mtip=%b required mtip=%b",
                         11 + k, mtime, mtip, (11 + k >= 21));
            end
            cyc();
        end
        axi_write(12'h008, 32'hFFFF_FFFF, 4'hF, 2'b00);
        checks++;
        if (mtip !== 1'b0) begin
            errors++;
            $display("FAIL mtip_drop: mtip=%b required 0", mtip);
        end
    endtask

    task automatic test_w_before_aw();
        axi_write(12'h010, 32'd0, 4'hF, 2'b00);
        bq.push_back(2'b00);
        s_bready = 1'b0;
        s_wdata = 32'h0000_1234; s_wstrb = 4'hF; s_wvalid = 1'b1;
        checks++;
        if (s_wready !== 1'b1) begin
            errors++;
            $display("FAIL w_first_ready: wready=%b required 1", s_wready);
        end
        cyc();
        s_wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (s_wready !== 1'b0 || s_awready !== 1'b1 || s_bvalid !== 1'b0) begin
                errors++;
                $display("FAIL w_held i=%0d: wready=%b awready=%b bvalid=%b required 0 1 0",
                         i, s_wready, s_awready, s_bvalid);
            end
            if (i == 2) begin
                s_awaddr = 12'h008; s_awvalid = 1'b1;
            end
            cyc();
        end
        s_awaddr = 12'h008; s_wdata = 32'h0000_5678; s_awvalid = 1'b1; s_wvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (s_bvalid !== 1'b1 || s_awready !== 1'b0 || s_wready !== 1'b0) begin
                errors++;
                $display("FAIL b_stall i=%0d: bvalid=%b awready=%b wready=%b required 1 0 0",
                         i, s_bvalid, s_awready, s_wready);
            end
            if (i == 0) begin
                logic [1:0] e;
                e = bq.pop_front();
                checks++;
                if (s_bresp !== e) begin
                    errors++;
                    $display("FAIL b_stall_resp: got %b required %b", s_bresp, e);
                end
            end
            cyc();
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
        cyc();
        checks++;
        if (s_bvalid !== 1'b0) begin
            errors++;
            $display("FAIL b_release: bvalid=%b required 0", s_bvalid);
        end
        axi_read(12'h008, 32'h0000_1234, 2'b00);
    endtask

    task automatic test_ctrl_strobe();
        axi_write(12'h000, 32'h1122_3344, 4'hF, 2'b00);
        axi_write(12'h004, 32'h0000_0005, 4'hF, 2'b00);
        repeat (10) cyc();
        checks++;
        if (mtime !== 64'h5_1122_3344) begin
            errors++;
            $display("FAIL frozen: mtime=%h required 0000000511223344", mtime);
        end
        axi_write(12'h000, 32'h0000_AB00, 4'b0010, 2'b00);
        checks++;
        if (mtime !== 64'h5_1122_AB44) begin
            errors++;
            $display("FAIL strobe_lo: mtime=%h required 000000051122ab44", mtime);
        end
        axi_write(12'h004, 32'hAA00_0000, 4'b1000, 2'b00);
        checks++;
        if (mtime !== 64'hAA00_0005_1122_AB44) begin
            errors++;
            $display("FAIL strobe_hi: mtime=%h required aa0000051122ab44", mtime);
        end
        axi_read(12'h000, 32'h1122_AB44, 2'b00);
        axi_read(12'h004, 32'hAA00_0005, 2'b00);
        axi_read(12'h020, 32'd0, 2'b10);
        axi_read(12'h01C, 32'd0, 2'b10);
        axi_read(12'h010, 32'd0, 2'b00);
        axi_write(12'h020, 32'hDEAD_BEEF, 4'hF, 2'b10);
        checks++;
        if (mtime !== 64'hAA00_0005_1122_AB44) begin
            errors++;
            $display("FAIL unmapped_write: mtime=%h required aa0000051122ab44", mtime);
        end
    endtask

    task automatic test_back_to_back();
        int got = 0;
        axi_write(12'h010, 32'd1, 4'hF, 2'b00);
        s_araddr = 12'h010; s_arvalid = 1'b1; s_rready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (s_arready) begin
                rq_data.push_back(32'd1);
                rq_resp.push_back(2'b00);
            end
            cyc();
            if (s_rvalid) begin
                logic [31:0] ed;
                logic [1:0]  er;
                got++;
                ed = rq_data.pop_front();
                er = rq_resp.pop_front();
                checks++;
                if (s_rdata !== ed || s_rresp !== er) begin
                    errors++;
                    $display("FAIL b2b_data: rdata=%h rresp=%b required %h %b", s_rdata, s_rresp, ed, er);
                end
            end
        end
        s_arvalid = 1'b0;
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL b2b_rate: %0d reads in 8 cycles required 4", got);
        end
        cyc();
        cyc();
    endtask

    task automatic test_async_reset();
        axi_write(12'h008, 32'd0, 4'hF, 2'b00);
        axi_read(12'h010, 32'd1, 2'b00);
        s_bready = 1'b0;
        s_awaddr = 12'h00C; s_wdata = 32'd0; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
        cyc();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        checks++;
        if (s_bvalid !== 1'b1 || mtip !== 1'b1 || mtime === 64'd0 || s_rdata !== 32'd1) begin
            errors++;
            $display("FAIL pre_reset: bvalid=%b mtip=%b mtime=%h rdata=%h required 1 1 nonzero 1",
                     s_bvalid, mtip, mtime, s_rdata);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mtime !== 64'd0 || mtip !== 1'b0 || s_bvalid !== 1'b0 || s_rvalid !== 1'b0 ||
            s_bresp !== 2'b00 || s_rresp !== 2'b00 || s_rdata !== 32'd0 || d3_mtime !== 64'd0 ||
            {s_awready, s_wready, s_arready} !== 3'b111) begin
            errors++;
            $display("FAIL async_reset: mtime=%h mtip=%b bvalid=%b rvalid=%b rdata=%h readies=%b presc3=%h",
                     mtime, mtip, s_bvalid, s_rvalid, s_rdata, {s_awready, s_wready, s_arready}, d3_mtime);
        end
        cyc();
        s_bready = 1'b1;
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_mtip();
        test_w_before_aw();
        test_ctrl_strobe();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
